// File: rtl/fetch_ctrl.sv
// Fetch-stage sequencer: owns the PC and the IF/ID register, picks the next
// fetch address (sequential, redirect, exception vector or hold) and
// registers the instruction returned by the asynchronous instruction memory.
module fetch_ctrl #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] EXC_VEC  = 32'h0000_0180
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    input  logic        exc_i,
    input  logic        halt_i,
    input  logic [31:0] instr_i,
    output logic [29:0] pc_o,
    output logic        if_valid_o,
    output logic [31:0] if_instr_o,
    output logic [31:0] if_pc_add4_o,
    output logic        adel_o,
    output logic        halted_o,
    output logic [15:0] flush_cnt_o
);

    localparam int unsigned XLEN = 32;
    localparam int unsigned PCW  = 30;
    localparam int unsigned CNTW = 16;

    typedef enum logic [0:0] {
        ST_RUN  = 1'b0,
        ST_HALT = 1'b1
    } state_t;

    state_t            state_q, state_d;
    logic [PCW-1:0]    pc_d;
    logic              valid_d;
    logic [XLEN-1:0]   instr_d;
    logic [XLEN-1:0]   add4_d;
    logic              adel_d;
    logic              halted_d;
    logic [CNTW-1:0]   cnt_d;
    logic              flush;
    logic [PCW-1:0]    pc_inc;

    // 30-bit word increment wraps naturally at the top of the address space
    assign pc_inc = pc_o + PCW'(1);

    // State and pipeline register update with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_RUN;
            pc_o         <= RESET_PC[31:2];
            if_valid_o   <= 1'b0;
            if_instr_o   <= '0;
            if_pc_add4_o <= '0;
            adel_o       <= 1'b0;
            halted_o     <= 1'b0;
            flush_cnt_o  <= '0;
        end else begin
            state_q      <= state_d;
            pc_o         <= pc_d;
            if_valid_o   <= valid_d;
            if_instr_o   <= instr_d;
            if_pc_add4_o <= add4_d;
            adel_o       <= adel_d;
            halted_o     <= halted_d;
            flush_cnt_o  <= cnt_d;
        end
    end

    // Next-PC selection, IF/ID update, flush accounting and state transitions
    always_comb begin
        state_d  = state_q;
        pc_d     = pc_o;
        valid_d  = if_valid_o;
        instr_d  = if_instr_o;
        add4_d   = if_pc_add4_o;
        adel_d   = 1'b0;
        halted_d = halted_o;
        cnt_d    = flush_cnt_o;
        flush    = 1'b0;

        case (state_q)
            ST_RUN: begin
                if (exc_i) begin
                    pc_d  = EXC_VEC[31:2];
                    flush = 1'b1;
                end else if (redirect_i) begin
                    // a redirect wins over stall: the stalled ID slot is wrong-path
                    if (redirect_pc_i[1:0] != 2'b00) begin
                        pc_d   = EXC_VEC[31:2];
                        adel_d = 1'b1;
                    end else begin
                        pc_d = redirect_pc_i[31:2];
                    end
                    flush = 1'b1;
                end else if (halt_i) begin
                    state_d  = ST_HALT;
                    halted_d = 1'b1;
                    flush    = 1'b1;
                end else if (stall_i) begin
                    pc_d = pc_o;
                end else begin
                    valid_d = 1'b1;
                    instr_d = instr_i;
                    add4_d  = {pc_inc, 2'b00};
                    pc_d    = pc_inc;
                end
            end
            ST_HALT: begin
                valid_d  = 1'b0;
                instr_d  = '0;
                halted_d = 1'b1;
            end
            default: begin
                state_d = ST_RUN;
            end
        endcase

        // squash IF/ID; only a real instruction counts as a flushed slot
        if (flush) begin
            valid_d = 1'b0;
            instr_d = '0;
            add4_d  = '0;
            if (if_valid_o && (flush_cnt_o != {CNTW{1'b1}})) begin
                cnt_d = flush_cnt_o + CNTW'(1);
            end
        end
    end

endmodule
